// File: rtl/mmu_tlb.sv
// mmu_tlb: NUM_CH-wide VA->PA translator; kseg0/kseg1 direct mapped, other segments via a dual-page TLB.
// Define MMU_UNCACHE_WINDOW_EN to force data-channel kseg0 0x8010_0000-0x803F_FFFF uncached.
module mmu_tlb #(
    parameter int                NUM_CH      = 4,
    parameter logic [NUM_CH-1:0] DATA_MASK   = 4'b1100,
    parameter int                TLB_ENTRIES = 8,
    parameter int                IDX_W       = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stall,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [NUM_CH-1:0]     req_wr,
    input  logic [32*NUM_CH-1:0]  vaddr,
    input  logic [7:0]            cur_asid,
    output logic [NUM_CH-1:0]     resp_valid,
    output logic [32*NUM_CH-1:0]  paddr,
    output logic [NUM_CH-1:0]     no_cache,
    output logic [NUM_CH-1:0]     tlb_refill,
    output logic [NUM_CH-1:0]     tlb_invalid,
    output logic [NUM_CH-1:0]     tlb_mod,
    input  logic                  tlb_we,
    input  logic [IDX_W-1:0]      tlb_widx,
    input  logic [26:0]           w_entryhi,
    input  logic [25:0]           w_lo0,
    input  logic [25:0]           w_lo1,
    input  logic [IDX_W-1:0]      tlb_ridx,
    output logic [26:0]           r_entryhi,
    output logic [25:0]           r_lo0,
    output logic [25:0]           r_lo1,
    input  logic                  probe_req,
    input  logic [26:0]           p_entryhi,
    output logic                  probe_hit,
    output logic [IDX_W-1:0]      probe_idx,
    output logic [IDX_W-1:0]      random_idx
);
`ifdef MMU_UNCACHE_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_ENTRIES - 1);

    // Page halves hold {PFN[19:0], C[2:0], D, V}; G is kept once per entry.
    logic [18:0]            vpn2_q [TLB_ENTRIES];
    logic [7:0]             asid_q [TLB_ENTRIES];
    logic [24:0]            lo0_q  [TLB_ENTRIES];
    logic [24:0]            lo1_q  [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] g_q;

    logic [NUM_CH-1:0]      resp_valid_q, nc_q, rf_q, inv_q, mod_q;
    logic [32*NUM_CH-1:0]   paddr_q;
    logic [NUM_CH-1:0]      nc_d, rf_d, inv_d, mod_d;
    logic [31:0]            pa_d [NUM_CH];
    logic [26:0]            r_entryhi_q;
    logic [25:0]            r_lo0_q, r_lo1_q;
    logic                   probe_hit_q;
    logic [IDX_W-1:0]       probe_idx_q, rnd_q;
    logic [IDX_W:0]         p_res;

    // Returns {hit, index}; scanning downwards lets the lowest matching index win.
    function automatic logic [IDX_W:0] lookup(input logic [18:0] vpn2, input logic [7:0] asid);
        lookup = '0;
        for (int e = TLB_ENTRIES - 1; e >= 0; e--)
            if (vpn2_q[e] == vpn2 && (g_q[e] || asid_q[e] == asid))
                lookup = {1'b1, IDX_W'(e)};
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0]    va;
        logic [IDX_W:0] hs;
        logic [24:0]    lo;
        logic           mapped, fault, win;
        assign va       = vaddr[32*c +: 32];
        assign mapped   = va[31:30] != 2'b10;
        assign hs       = lookup(va[31:13], cur_asid);
        assign lo       = va[12] ? lo1_q[hs[IDX_W-1:0]] : lo0_q[hs[IDX_W-1:0]];
        assign rf_d[c]  = mapped & ~hs[IDX_W];
        assign inv_d[c] = mapped & hs[IDX_W] & ~lo[0];
        assign mod_d[c] = mapped & hs[IDX_W] & lo[0] & ~lo[1] & req_wr[c];
        assign fault    = rf_d[c] | inv_d[c] | mod_d[c];
        assign win      = WIN_EN && DATA_MASK[c] && va >= 32'h8010_0000 && va <= 32'h803F_FFFF;
        assign pa_d[c]  = !mapped ? {3'b000, va[28:0]} : fault ? 32'h0 : {lo[24:5], va[11:0]};
        assign nc_d[c]  = !mapped ? (va[29] | win) : (!fault && lo[4:2] == 3'd2);
    end

    assign p_res = lookup(p_entryhi[26:8], p_entryhi[7:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            g_q <= '0;
            for (int e = 0; e < TLB_ENTRIES; e++) begin
                vpn2_q[e] <= '0;
                asid_q[e] <= '0;
                lo0_q[e]  <= '0;
                lo1_q[e]  <= '0;
            end
        end else if (tlb_we) begin
            vpn2_q[tlb_widx] <= w_entryhi[26:8];
            asid_q[tlb_widx] <= w_entryhi[7:0];
            lo0_q[tlb_widx]  <= w_lo0[25:1];
            lo1_q[tlb_widx]  <= w_lo1[25:1];
            g_q[tlb_widx]    <= w_lo0[0] & w_lo1[0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= '0;
            nc_q         <= '0;
            rf_q         <= '0;
            inv_q        <= '0;
            mod_q        <= '0;
            paddr_q      <= '0;
        end else if (!stall) begin
            resp_valid_q <= req_valid;
            nc_q         <= nc_d;
            rf_q         <= rf_d & req_valid;
            inv_q        <= inv_d & req_valid;
            mod_q        <= mod_d & req_valid;
            for (int c = 0; c < NUM_CH; c++)
                paddr_q[32*c +: 32] <= pa_d[c];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_entryhi_q <= '0;
            r_lo0_q     <= '0;
            r_lo1_q     <= '0;
            probe_hit_q <= 1'b0;
            probe_idx_q <= '0;
            rnd_q       <= LAST;
        end else begin
            r_entryhi_q <= {vpn2_q[tlb_ridx], asid_q[tlb_ridx]};
            r_lo0_q     <= {lo0_q[tlb_ridx], g_q[tlb_ridx]};
            r_lo1_q     <= {lo1_q[tlb_ridx], g_q[tlb_ridx]};
            if (probe_req) begin
                probe_hit_q <= p_res[IDX_W];
                probe_idx_q <= p_res[IDX_W-1:0];
            end
            rnd_q <= rnd_q == '0 ? LAST : rnd_q - IDX_W'(1);
        end
    end

    assign resp_valid  = resp_valid_q;
    assign paddr       = paddr_q;
    assign no_cache    = nc_q;
    assign tlb_refill  = rf_q;
    assign tlb_invalid = inv_q;
    assign tlb_mod     = mod_q;
    assign r_entryhi   = r_entryhi_q;
    assign r_lo0       = r_lo0_q;
    assign r_lo1       = r_lo1_q;
    assign probe_hit   = probe_hit_q;
    assign probe_idx   = probe_idx_q;
    assign random_idx  = rnd_q;
endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed plus randomized checks of mmu_tlb against a table-level reference model.
module tb_mmu_tlb;
    localparam int NC = 4;
    localparam int E  = 8;
    localparam int IW = 3;
`ifdef MMU_UNCACHE_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn, stall;
    logic [NC-1:0]     req_valid, req_wr;
    logic [32*NC-1:0]  vaddr;
    logic [7:0]        cur_asid;
    logic [NC-1:0]     resp_valid, no_cache, tlb_refill, tlb_invalid, tlb_mod;
    logic [32*NC-1:0]  paddr;
    logic              tlb_we, probe_req, probe_hit;
    logic [IW-1:0]     tlb_widx, tlb_ridx, probe_idx, random_idx;
    logic [26:0]       w_entryhi, r_entryhi, p_entryhi;
    logic [25:0]       w_lo0, w_lo1, r_lo0, r_lo1;

    mmu_tlb #(.NUM_CH(NC), .DATA_MASK(4'b1100), .TLB_ENTRIES(E), .IDX_W(IW)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .req_valid(req_valid), .req_wr(req_wr),
        .vaddr(vaddr), .cur_asid(cur_asid), .resp_valid(resp_valid), .paddr(paddr),
        .no_cache(no_cache), .tlb_refill(tlb_refill), .tlb_invalid(tlb_invalid), .tlb_mod(tlb_mod),
        .tlb_we(tlb_we), .tlb_widx(tlb_widx), .w_entryhi(w_entryhi), .w_lo0(w_lo0), .w_lo1(w_lo1),
        .tlb_ridx(tlb_ridx), .r_entryhi(r_entryhi), .r_lo0(r_lo0), .r_lo1(r_lo1),
        .probe_req(probe_req), .p_entryhi(p_entryhi), .probe_hit(probe_hit), .probe_idx(probe_idx),
        .random_idx(random_idx)
    );

    always #5 clk = ~clk;

    // Reference TLB contents, one field per array.
    logic [18:0] m_vpn  [E];
    logic [7:0]  m_asid [E];
    logic        m_g    [E];
    logic [19:0] m_pfn  [E][2];
    logic [2:0]  m_c    [E][2];
    logic        m_d    [E][2];
    logic        m_v    [E][2];

    logic        e_valid [NC], e_nc [NC], e_rf [NC], e_iv [NC], e_md [NC];
    logic [31:0] e_pa    [NC];
    logic        e_ph;
    int          e_pi;
    logic [26:0] e_rhi;
    logic [25:0] e_rlo0, e_rlo1;
    int          n_chk = 0, n_fail = 0, cycles = 0;
    logic [18:0] pool [5] = '{19'h00200, 19'h00201, 19'h10000, 19'h60000, 19'h7FFFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int find(input logic [18:0] vpn, input logic [7:0] asid);
        for (int i = 0; i < E; i++)
            if (m_vpn[i] == vpn && (m_g[i] || m_asid[i] == asid)) return i;
        return -1;
    endfunction

    task automatic xlate(input logic [31:0] va, input logic wr, input int ch,
                         output logic [31:0] pa, output logic nc, rf, iv, md);
        int i, pg;
        pa = 32'h0; nc = 1'b0; rf = 1'b0; iv = 1'b0; md = 1'b0;
        if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
            pa = va - (va >= 32'hA000_0000 ? 32'hA000_0000 : 32'h8000_0000);
            nc = va >= 32'hA000_0000 || (WIN && ch >= 2 && va >= 32'h8010_0000 && va < 32'h8040_0000);
        end else begin
            i  = find(va[31:13], cur_asid);
            pg = int'(va[12]);
            if (i < 0) rf = 1'b1;
            else if (!m_v[i][pg]) iv = 1'b1;
            else if (!m_d[i][pg] && wr) md = 1'b1;
            else begin
                pa = {m_pfn[i][pg], va[11:0]};
                nc = m_c[i][pg] == 3'd2;
            end
        end
    endtask

    task automatic m_write(input int idx, input logic [26:0] hi, input logic [25:0] l0, input logic [25:0] l1);
        m_vpn[idx]  = hi[26:8];
        m_asid[idx] = hi[7:0];
        m_g[idx]    = l0[0] & l1[0];
        m_pfn[idx][0] = l0[25:6]; m_c[idx][0] = l0[5:3]; m_d[idx][0] = l0[2]; m_v[idx][0] = l0[1];
        m_pfn[idx][1] = l1[25:6]; m_c[idx][1] = l1[5:3]; m_d[idx][1] = l1[2]; m_v[idx][1] = l1[1];
    endtask

    function automatic logic [25:0] m_lo(input int idx, input int pg);
        return {m_pfn[idx][pg], m_c[idx][pg], m_d[idx][pg], m_v[idx][pg], m_g[idx]};
    endfunction

    // One clock: predict from current inputs and old table, clock, update table, compare.
    task automatic tick();
        logic [31:0] pa;
        logic nc, rf, iv, md;
        int pi;
        if (!stall)
            for (int c = 0; c < NC; c++) begin
                xlate(vaddr[32*c +: 32], req_wr[c], c, pa, nc, rf, iv, md);
                e_valid[c] = req_valid[c]; e_pa[c] = pa; e_nc[c] = nc;
                e_rf[c] = rf & req_valid[c]; e_iv[c] = iv & req_valid[c]; e_md[c] = md & req_valid[c];
            end
        if (probe_req) begin
            pi = find(p_entryhi[26:8], p_entryhi[7:0]);
            e_ph = pi >= 0;
            e_pi = pi;
        end
        e_rhi  = {m_vpn[tlb_ridx], m_asid[tlb_ridx]};
        e_rlo0 = m_lo(int'(tlb_ridx), 0);
        e_rlo1 = m_lo(int'(tlb_ridx), 1);
        @(posedge clk); #1;
        cycles++;
        if (tlb_we) m_write(int'(tlb_widx), w_entryhi, w_lo0, w_lo1);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("resp_valid%0d", c), 32'(resp_valid[c]), 32'(e_valid[c]));
            chk($sformatf("paddr%0d", c), paddr[32*c +: 32], e_pa[c]);
            chk($sformatf("no_cache%0d", c), 32'(no_cache[c]), 32'(e_nc[c]));
            chk($sformatf("refill%0d", c), 32'(tlb_refill[c]), 32'(e_rf[c]));
            chk($sformatf("invalid%0d", c), 32'(tlb_invalid[c]), 32'(e_iv[c]));
            chk($sformatf("mod%0d", c), 32'(tlb_mod[c]), 32'(e_md[c]));
        end
        chk("probe_hit", 32'(probe_hit), 32'(e_ph));
        if (e_ph) chk("probe_idx", 32'(probe_idx), 32'(e_pi));
        chk("r_entryhi", 32'(r_entryhi), 32'(e_rhi));
        chk("r_lo0", 32'(r_lo0), 32'(e_rlo0));
        chk("r_lo1", 32'(r_lo1), 32'(e_rlo1));
        chk("random_idx", 32'(random_idx), 32'(7 - (cycles % 8)));
    endtask

    task automatic req(input int ch, input logic [31:0] va, input logic wr);
        vaddr[32*ch +: 32] = va;
        req_valid[ch] = 1'b1;
        req_wr[ch] = wr;
    endtask

    task automatic wr_entry(input int idx, input logic [26:0] hi, input logic [25:0] l0, input logic [25:0] l1);
        tlb_we = 1'b1; tlb_widx = IW'(idx); w_entryhi = hi; w_lo0 = l0; w_lo1 = l1;
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; req_valid = '0; req_wr = '0; vaddr = '0; cur_asid = '0;
        tlb_we = 1'b0; tlb_widx = '0; w_entryhi = '0; w_lo0 = '0; w_lo1 = '0;
        tlb_ridx = '0; probe_req = 1'b0; p_entryhi = '0;
        for (int i = 0; i < E; i++) m_write(i, 27'h0, 26'h0, 26'h0);
        for (int c = 0; c < NC; c++) begin
            e_valid[c] = 0; e_pa[c] = 0; e_nc[c] = 0; e_rf[c] = 0; e_iv[c] = 0; e_md[c] = 0;
        end
        e_ph = 1'b0; e_pi = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("reset_random_idx", 32'(random_idx), 32'd7);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_probe_hit", 32'(probe_hit), 32'd0);
        chk("reset_paddr0", paddr[31:0], 32'd0);
        chk("reset_r_lo0", 32'(r_lo0), 32'd0);

        repeat (9) tick();
        probe_req = 1'b1; p_entryhi = {19'h12345, 8'd3};
        tick();
        chk("probe_miss", 32'(probe_hit), 32'd0);
        probe_req = 1'b0;

        req(0, 32'h9FC0_0000, 1'b0); req(2, 32'hBFC0_0004, 1'b0);
        tick();
        chk("kseg0_pa", paddr[31:0], 32'h1FC0_0000);
        chk("kseg0_nc", 32'(no_cache[0]), 32'd0);
        chk("kseg1_pa", paddr[95:64], 32'h1FC0_0004);
        chk("kseg1_nc", 32'(no_cache[2]), 32'd1);
        req_valid = '0;

        cur_asid = 8'd5;
        wr_entry(3, {19'h00200, 8'd5}, {20'h01234, 3'd3, 1'b1, 1'b1, 1'b0}, 26'h0);
        tlb_ridx = 3'd3;
        tick();
        tlb_we = 1'b0;
        req(0, 32'h0040_0ABC, 1'b0); req(2, 32'h0040_1000, 1'b0);
        tick();
        chk("tlb_hit_pa", paddr[31:0], 32'h0123_4ABC);
        chk("tlb_lo1_invalid", 32'(tlb_invalid[2]), 32'd1);
        chk("r_entryhi_idx3", 32'(r_entryhi), {5'd0, 19'h00200, 8'd5});
        cur_asid = 8'd6;
        tick();
        chk("asid_refill", 32'(tlb_refill[0]), 32'd1);
        cur_asid = 8'd5;
        probe_req = 1'b1; p_entryhi = {19'h00200, 8'd5};
        wr_entry(3, {19'h00200, 8'd5}, {20'h01234, 3'd3, 1'b0, 1'b1, 1'b0}, 26'h0);
        tick();
        chk("probe_hit3", 32'(probe_hit), 32'd1);
        chk("probe_idx3", 32'(probe_idx), 32'd3);
        probe_req = 1'b0; tlb_we = 1'b0; req_valid = '0;
        req(3, 32'h0040_0000, 1'b1);
        tick();
        chk("mod_flag", 32'(tlb_mod[3]), 32'd1);
        chk("mod_pa", paddr[127:96], 32'd0);
        req_wr[3] = 1'b0;
        tick();
        chk("load_pa", paddr[127:96], 32'h0123_4000);
        req_valid = '0;

        wr_entry(5, {19'h00300, 8'd5}, {20'h0ABCD, 3'd3, 1'b1, 1'b1, 1'b0}, 26'h0);
        req(1, 32'h0060_0010, 1'b0);
        tick();
        chk("wr_same_cycle_refill", 32'(tlb_refill[1]), 32'd1);
        tlb_we = 1'b0;
        tick();
        chk("wr_next_cycle_hit", paddr[63:32], 32'h0ABC_D010);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vaddr[63:32] = 32'h9000_0000 + 32'(i * 32'h100);
            req_valid = 4'(i + 5);
            tick();
        end
        chk("stall_hold_pa", paddr[63:32], 32'h0ABC_D010);
        stall = 1'b0; req_valid = '0;

        req(2, 32'h8020_0000, 1'b0); req(0, 32'h8020_0000, 1'b0); req(3, 32'h8040_0000, 1'b0);
        tick();
        chk("win_data_nc", 32'(no_cache[2]), 32'(WIN));
        chk("win_inst_nc", 32'(no_cache[0]), 32'd0);
        chk("win_outside_nc", 32'(no_cache[3]), 32'd0);

        for (int n = 0; n < 400; n++) begin
            tlb_we = $urandom_range(0, 3) == 0;
            if (tlb_we)
                wr_entry($urandom_range(0, E - 1), {pool[$urandom_range(0, 4)], 8'($urandom_range(1, 2))},
                         26'($urandom), 26'($urandom));
            cur_asid  = 8'($urandom_range(1, 2));
            stall     = $urandom_range(0, 4) == 0;
            req_valid = 4'($urandom);
            req_wr    = 4'($urandom);
            for (int c = 0; c < NC; c++)
                vaddr[32*c +: 32] = $urandom_range(0, 3) == 0
                    ? 32'h8000_0000 + ($urandom & 32'h3FFF_FFFF)
                    : {pool[$urandom_range(0, 4)], 13'($urandom)};
            tlb_ridx  = IW'($urandom);
            probe_req = $urandom_range(0, 2) == 0;
            p_entryhi = {pool[$urandom_range(0, 4)], 8'($urandom_range(1, 2))};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Parametrised successor to the fixed-mapping address translator.
- Translates NUM_CH virtual addresses per cycle:
  - kseg0/kseg1 are direct-mapped.
  - kuseg, kseg2 and kseg3 are translated through a fully associative, MIPS32-style dual-page TLB.
- Lookup results are registered: one cycle latency, with stall/hold.
- Sits between the fetch/LSU address stage and the caches; CP0 drives the write, read and probe ports for TLBWI/TLBWR/TLBR/TLBP.

Parameters:
NUM_CH, 4, number of lookup channels (ch0-1 inst, ch2-3 data by default)
DATA_MASK, 4'b1100, bit i set = channel i is a data channel
TLB_ENTRIES, 8, TLB entries (power of two, 2..32)
IDX_W, 3, log2(TLB_ENTRIES)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
stall  in  1  hold all lookup output registers
req_valid  in  NUM_CH  lookup request per channel
req_wr  in  NUM_CH  request is a store (for modify check)
vaddr  in  32*NUM_CH  virtual addresses, channel i at [32i+31:32i]
cur_asid  in  8  current ASID from CP0 EntryHi
resp_valid  out  NUM_CH  registered request valid
paddr  out  32*NUM_CH  physical addresses
no_cache  out  NUM_CH  uncached access
tlb_refill  out  NUM_CH  no matching entry (mapped segment)
tlb_invalid  out  NUM_CH  matching entry with V=0
tlb_mod  out  NUM_CH  store to matching entry with V=1, D=0
tlb_we  in  1  write entry at tlb_widx
tlb_widx  in  IDX_W  write index
w_entryhi  in  27  {VPN2[18:0], ASID[7:0]}
w_lo0, w_lo1  in  26 each  {PFN[19:0], C[2:0], D, V, G}
tlb_ridx  in  IDX_W  read index
r_entryhi  out  27  registered read data
r_lo0, r_lo1  out  26 each  registered read data; G read back as stored G of lo0 AND lo1
probe_req  in  1  probe with p_entryhi
p_entryhi  in  27  probe key
probe_hit  out  1  registered probe result
probe_idx  out  IDX_W  matching index (valid when probe_hit)
random_idx  out  IDX_W  Random register for TLBWR

Behaviour:
- Reset (async, resetn=0):
  - All entry V and G bits and all VPN2/ASID/PFN fields cleared.
  - resp_valid, tlb_refill, tlb_invalid, tlb_mod, no_cache, probe_hit cleared.
  - paddr, probe_idx, r_* cleared.
  - random_idx = TLB_ENTRIES-1.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr = {3'b0, vaddr[28:0]}, cached.
  - 101 (kseg1): same mapping, no_cache=1.
  - All other values: mapped.
- Match, entry e:
  - VPN2_e == vaddr[31:13], and (G_e or ASID_e == cur_asid).
  - Page select by vaddr[12]: 0 uses lo0, 1 uses lo1.
  - paddr = {PFN, vaddr[11:0]}.
  - no_cache = (C == 3'd2).
  - Multiple hits: lowest index wins.
- Faults (mapped only, exactly one flag or none; all gated by req_valid):
  - No match: tlb_refill.
  - Selected V=0: tlb_invalid.
  - V=1, D=0 and req_wr: tlb_mod.
  - paddr is 0 on any fault.
- Latency: outputs register at the clk edge after the request.
  - stall=1: all lookup outputs hold.
  - req_valid=0 and stall=0: resp_valid=0 and fault flags=0.
- TLB write:
  - G stored as w_lo0.G & w_lo1.G.
  - Write and lookup in the same cycle: the lookup uses the old contents; the new entry is visible from the next cycle.
  - Writes are not gated by stall.
- Read: r_* registered one cycle after tlb_ridx is presented; updated every cycle.
- Probe:
  - Compares p_entryhi VPN2 and ASID with the same G rule.
  - probe_hit/probe_idx are registered the cycle after probe_req and hold until the next probe_req.
  - Probe in the same cycle as a write sees the old contents.
- random_idx:
  - Decrements every cycle; wraps 0 -> TLB_ENTRIES-1.
  - When tlb_we is asserted with tlb_widx == random_idx, the next value is still the normal decrement.

Optional Feature:
MMU_UNCACHE_WINDOW_EN:
- Defined: data channels (DATA_MASK bit set) accessing kseg0 virtual 0x8010_0000-0x803F_FFFF get no_cache=1. This is the monitor user-code area, kept uncached so no I/D cache coherence is needed. Inst channels are unaffected.
- Undefined: kseg0 is always cached.

Test Plan:
- Reset -> after resetn=1: random_idx=7, then 6, 5, ... 0, 7. resp_valid=0. Probe of any key -> probe_hit=0.
- ch0 vaddr 0x9FC0_0000 and ch2 vaddr 0xBFC0_0004, req_valid -> next cycle: paddr0=0x1FC0_0000, no_cache0=0; paddr2=0x1FC0_0004, no_cache2=1; no faults.
- Write idx 3: VPN2=0x00200, ASID=5, lo0 PFN=0x01234 C=3 D=1 V=1, lo1 V=0. With cur_asid=5:
  - Lookup 0x0040_0ABC -> paddr 0x0123_4ABC.
  - Lookup 0x0040_1000 -> tlb_invalid=1.
  - cur_asid=6 -> tlb_refill=1.
- Same entry with D=0, req_wr=1 to 0x0040_0000 -> tlb_mod=1, paddr=0. req_wr=0 -> paddr=0x0123_4000.
- Write and lookup to the same page in one cycle -> refill that cycle, hit the next. Assert stall for 3 cycles with changing vaddr -> outputs frozen.
- With MMU_UNCACHE_WINDOW_EN:
  - ch2 at 0x8020_0000 -> no_cache=1.
  - ch0 at 0x8020_0000 -> no_cache=0.
  - ch2 at 0x8040_0000 -> no_cache=0.
  - Without the macro: all three -> no_cache=0.
